// File: rtl/constraint_sampler_pkg.sv
// Shared types and helpers for the rejection-sampling stimulus drivers:
// LFSR constants, FSM state encoding and candidate-width arithmetic.
package constraint_sampler_pkg;

  localparam int                LFSR_W    = 64;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800000000000000;

  typedef enum logic [2:0] {IDLE, FILL, CHECK, HOLD, DONE} state_e;

  function automatic int words_for(int data_w);
    return (data_w + LFSR_W - 1) / LFSR_W;
  endfunction

  // Galois step for x^64+x^63+x^61+x^60+1
  function automatic logic [LFSR_W-1:0] lfsr_next(logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/lfsr64_galois.sv
// 64-bit Galois LFSR with synchronous load; load wins over step.
// Reusable by any sampler that needs a reseedable pseudo-random word source.
module lfsr64_galois
  import constraint_sampler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 64'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state_q <= SEED;
    else if (load) state_q <= load_val;
    else if (step) state_q <= lfsr_next(state_q);
  end

  assign state = state_q;

endmodule

// File: rtl/constraint_sample_driver.sv
// Rejection sampler: fills a candidate from the LFSR, asks the checker for a
// verdict and hands accepted candidates downstream over valid/ready.
//   state | meaning
//   IDLE  | waiting for start, seed may be reloaded
//   FILL  | shifting one LFSR word per cycle into the candidate
//   CHECK | candidate stable, waiting out checker latency, then sampling x
//   HOLD  | accepted candidate offered to the sink
//   DONE  | one-cycle end-of-run pulse
module constraint_sample_driver
  import constraint_sampler_pkg::*;
#(
  parameter int                DATA_W    = 779,
  parameter int                CHK_LAT   = 0,
  parameter int                MAX_TRIES = 1024,
  parameter logic [LFSR_W-1:0] SEED      = 64'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [15:0]       n_samples_i,
  input  logic              seed_load_i,
  input  logic [63:0]       seed_i,
  output logic [DATA_W-1:0] cand_o,
  input  logic              chk_x_i,
  output logic              smp_valid_o,
  input  logic              smp_ready_i,
  output logic [DATA_W-1:0] smp_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [31:0]       tries_o,
  output logic [15:0]       accepted_o
);

  localparam int WORDS = words_for(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cand_q, cand_d, cand_shift;
  logic [15:0]       n_q, n_d, acc_q, acc_d;
  logic [15:0]       fill_q, fill_d, lat_q, lat_d;
  logic [31:0]       tries_q, tries_d, rej_q, rej_d;
  logic              timeout_q, timeout_d;
  logic              lfsr_load, lfsr_step;
  logic [LFSR_W-1:0] lfsr_state, lfsr_word, seed_eff;

  assign seed_eff  = (seed_i == '0) ? 64'h1 : seed_i;
  assign lfsr_word = lfsr_next(lfsr_state);

  lfsr64_galois #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_eff),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  // Newest word enters the LSBs, so the first word of a fill ends up on top
  if (DATA_W > LFSR_W) begin : g_wide
    assign cand_shift = {cand_q[DATA_W-LFSR_W-1:0], lfsr_word};
  end else begin : g_narrow
    assign cand_shift = lfsr_word[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      n_q       <= '0;
      acc_q     <= '0;
      fill_q    <= '0;
      lat_q     <= '0;
      tries_q   <= '0;
      rej_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      n_q       <= n_d;
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      lat_q     <= lat_d;
      tries_q   <= tries_d;
      rej_q     <= rej_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    n_d       = n_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    lat_d     = lat_q;
    tries_d   = tries_q;
    rej_d     = rej_q;
    timeout_d = timeout_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        lfsr_load = seed_load_i;
        if (start_i) begin
          n_d       = n_samples_i;
          acc_d     = '0;
          tries_d   = '0;
          timeout_d = 1'b0;
          rej_d     = 32'(MAX_TRIES);
          fill_d    = 16'(WORDS - 1);
          state_d   = (n_samples_i == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        lfsr_step = 1'b1;
        cand_d    = cand_shift;
        if (fill_q == '0) begin
          lat_d   = 16'(CHK_LAT);
          state_d = CHECK;
        end else begin
          fill_d = fill_q - 16'd1;
        end
      end
      CHECK: begin
        if (lat_q == '0) begin
          tries_d = (tries_q == '1) ? tries_q : tries_q + 32'd1;
          if (chk_x_i) begin
            rej_d   = 32'(MAX_TRIES);
            state_d = HOLD;
          end else if (rej_q == 32'd1) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            rej_d   = rej_q - 32'd1;
            fill_d  = 16'(WORDS - 1);
            state_d = FILL;
          end
        end else begin
          lat_d = lat_q - 16'd1;
        end
      end
      HOLD: begin
        if (smp_ready_i) begin
          acc_d = acc_q + 16'd1;
          if ((acc_q + 16'd1) == n_q) begin
            state_d = DONE;
          end else begin
            fill_d  = 16'(WORDS - 1);
            state_d = FILL;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cand_o      = cand_q;
  assign smp_data_o  = cand_q;
  assign smp_valid_o = (state_q == HOLD);
  assign busy_o      = (state_q == FILL) || (state_q == CHECK) || (state_q == HOLD);
  assign done_o      = (state_q == DONE);
  assign timeout_o   = timeout_q;
  assign tries_o     = tries_q;
  assign accepted_o  = acc_q;

endmodule

// File: tb/tb_constraint_sample_driver.sv
// Bench for constraint_sample_driver: a default-width instance checked every
// cycle against a golden-LFSR sample model, plus a narrow timeout instance.
module tb_constraint_sample_driver;

  localparam int              DW_B    = 779;
  localparam int              WORDS_B = 13;
  localparam logic [63:0]     TAPS    = 64'hD800000000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic            b_start = 0, b_sl = 0, b_chk = 1, b_ready = 1;
  logic [15:0]     b_n = 0;
  logic [63:0]     b_seed = 0;
  logic [DW_B-1:0] b_cand, b_data;
  logic            b_valid, b_busy, b_done, b_to;
  logic [31:0]     b_tries;
  logic [15:0]     b_acc;

  // narrow instance: one word, checker latency 2, four tries
  logic            a_start = 0, a_sl = 0, a_chk = 1, a_ready = 1;
  logic [15:0]     a_n = 0;
  logic [63:0]     a_seed = 0;
  logic [63:0]     a_cand, a_data;
  logic            a_valid, a_busy, a_done, a_to;
  logic [31:0]     a_tries;
  logic [15:0]     a_acc;

  constraint_sample_driver dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .n_samples_i(b_n),
    .seed_load_i(b_sl), .seed_i(b_seed), .cand_o(b_cand), .chk_x_i(b_chk),
    .smp_valid_o(b_valid), .smp_ready_i(b_ready), .smp_data_o(b_data),
    .busy_o(b_busy), .done_o(b_done), .timeout_o(b_to), .tries_o(b_tries),
    .accepted_o(b_acc)
  );

  constraint_sample_driver #(.DATA_W(64), .CHK_LAT(2), .MAX_TRIES(4)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .n_samples_i(a_n),
    .seed_load_i(a_sl), .seed_i(a_seed), .cand_o(a_cand), .chk_x_i(a_chk),
    .smp_valid_o(a_valid), .smp_ready_i(a_ready), .smp_data_o(a_data),
    .busy_o(a_busy), .done_o(a_done), .timeout_o(a_to), .tries_o(a_tries),
    .accepted_o(a_acc)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0]     g_lfsr = 64'h1;
  logic [DW_B-1:0] exp_q[$];
  int              model_acc = 0;

  function automatic logic [63:0] g_step(logic [63:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 64'h0);
  endfunction

  // Word i of a fill sits at 64-bit slot (WORDS-1-i) of the untruncated vector
  task automatic gen_cands(int n);
    logic [WORDS_B*64-1:0] big;
    for (int s = 0; s < n; s++) begin
      big = '0;
      for (int i = 0; i < WORDS_B; i++) begin
        g_lfsr = g_step(g_lfsr);
        big[(WORDS_B-1-i)*64 +: 64] = g_lfsr;
      end
      exp_q.push_back(big[DW_B-1:0]);
    end
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qget(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if (b_acc !== 16'(model_acc)) begin
        n_fail++;
        $display("FAIL b_accepted: got %0d expected %0d", b_acc, model_acc);
      end
      if (b_valid) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected_valid: got valid with data %0h expected no sample", b_data);
        end else if (b_data !== exp_q[0] || b_cand !== b_data) begin
          n_fail++;
          $display("FAIL b_sample: got %0h expected %0h", b_data, exp_q[0]);
        end
        if (b_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          model_acc++;
        end
      end
    end
  end

  task automatic start_b(int n, logic sl, logic [63:0] sd);
    @(posedge clk); #1;
    b_n = 16'(n); b_start = 1; b_sl = sl; b_seed = sd;
    @(posedge clk); #1;
    b_start = 0; b_sl = 0;
    model_acc = 0;
  endtask

  task automatic wait_b_done(int budget, output int k_done, output int n_valid);
    k_done = -1;
    n_valid = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (b_valid) n_valid++;
      if (b_done) begin
        k_done = k;
        break;
      end
    end
  endtask

  task automatic start_a(int n);
    @(posedge clk); #1;
    a_n = 16'(n); a_start = 1;
    @(posedge clk); #1;
    a_start = 0;
  endtask

  initial begin
    int              kd, nv, vcnt, stray;
    int              vk[$];
    logic [63:0]     got64;
    logic            got_v, got_d;
    logic [DW_B-1:0] d0;
    logic [31:0]     t0;

    // reset state
    #3;
    check("rst_b_busy", 64'(b_busy), 0);
    check("rst_b_valid", 64'(b_valid), 0);
    check("rst_b_done", 64'(b_done), 0);
    check("rst_b_timeout", 64'(b_to), 0);
    check("rst_b_tries", 64'(b_tries), 0);
    check("rst_b_acc", 64'(b_acc), 0);
    n_chk++;
    if (b_cand !== '0) begin
      n_fail++;
      $display("FAIL rst_b_cand: got %0h expected 0", b_cand);
    end
    check("rst_a_cand", a_cand, 0);
    #9 rst = 0;

    // model pins
    check("model_step1", g_step(64'h1), 64'hD800000000000000);
    check("model_step2", g_step(64'hD800000000000000), 64'h6C00000000000000);

    // narrow: seed 0 is replaced by 1, first word D8..0
    @(posedge clk); #1; a_sl = 1; a_seed = 64'h0;
    @(posedge clk); #1; a_sl = 0;
    a_chk = 1; a_ready = 1;
    start_a(1);
    got64 = '0; got_v = 0; got_d = 0;
    for (int k = 0; k < 40 && !got_d; k++) begin
      @(negedge clk);
      if (a_valid && a_ready) begin got64 = a_data; got_v = 1; end
      if (a_done) got_d = 1;
    end
    check("a_seed0_valid_seen", 64'(got_v), 1);
    check("a_seed0_data", got64, 64'hD800000000000000);
    check("a_seed0_done", 64'(got_d), 1);
    check("a_seed0_acc", 64'(a_acc), 1);
    check("a_seed0_tries", 64'(a_tries), 1);

    // narrow: checker always rejects -> timeout after four tries
    a_chk = 0;
    start_a(2);
    got_d = 0; vcnt = 0;
    for (int k = 0; k < 100 && !got_d; k++) begin
      @(negedge clk);
      if (a_valid) vcnt++;
      if (a_done) got_d = 1;
    end
    check("a_to_done", 64'(got_d), 1);
    check("a_to_no_valid", 64'(vcnt), 0);
    check("a_to_timeout", 64'(a_to), 1);
    check("a_to_tries", 64'(a_tries), 4);
    @(negedge clk);
    check("a_to_busy", 64'(a_busy), 0);
    check("a_to_sticky", 64'(a_to), 1);
    a_chk = 1;
    start_a(1);
    @(negedge clk);
    check("a_to_cleared", 64'(a_to), 0);
    for (int k = 0; k < 40 && a_busy; k++) @(negedge clk);

    // default: three samples, checker accepts, ready high
    b_chk = 1; b_ready = 1;
    gen_cands(3);
    start_b(3, 0, 64'h0);
    kd = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (b_valid) vk.push_back(k);
      if (b_done && kd < 0) kd = k;
    end
    check("b3_nvalid", 64'(vk.size()), 3);
    check("b3_valid1_cycle", 64'(qget(vk, 0)), 15);
    check("b3_valid2_cycle", 64'(qget(vk, 1)), 30);
    check("b3_valid3_cycle", 64'(qget(vk, 2)), 45);
    check("b3_done_cycle", 64'(kd), 46);
    check("b3_tries", 64'(b_tries), 3);
    check("b3_queue_drained", 64'(exp_q.size()), 0);
    check("b3_busy", 64'(b_busy), 0);

    // default: zero samples requested
    start_b(0, 0, 64'h0);
    @(negedge clk);
    check("b0_done_next", 64'(b_done), 1);
    check("b0_tries", 64'(b_tries), 0);
    vcnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (b_valid) vcnt++;
    end
    check("b0_no_valid", 64'(vcnt), 0);

    // default: sink stalls for ten cycles
    gen_cands(1);
    b_ready = 0;
    start_b(1, 0, 64'h0);
    got_v = 0;
    for (int k = 0; k < 40 && !got_v; k++) begin
      @(negedge clk);
      if (b_valid) got_v = 1;
    end
    check("bh_valid_seen", 64'(got_v), 1);
    d0 = b_data;
    t0 = b_tries;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!b_valid || b_data !== d0 || b_cand !== d0 || b_tries !== t0) stray++;
    end
    check("bh_stable_cycles_bad", 64'(stray), 0);
    @(posedge clk); #1; b_ready = 1;
    wait_b_done(5, kd, nv);
    check("bh_done", 64'(kd > 0), 1);
    check("bh_acc", 64'(b_acc), 1);
    check("bh_queue_drained", 64'(exp_q.size()), 0);

    // default: seed load together with start
    g_lfsr = 64'h0123456789ABCDEF;
    gen_cands(1);
    start_b(1, 1, 64'h0123456789ABCDEF);
    wait_b_done(40, kd, nv);
    check("bs_done", 64'(kd > 0), 1);
    check("bs_nvalid", 64'(nv), 1);
    check("bs_queue_drained", 64'(exp_q.size()), 0);

    // default: reset in the middle of a fill
    gen_cands(1);
    start_b(1, 0, 64'h0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    exp_q.delete();
    model_acc = 0;
    g_lfsr = 64'h1;
    #2 rst = 0;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_done || b_busy) stray++;
    end
    check("br_quiet_after_reset", 64'(stray), 0);
    gen_cands(1);
    start_b(1, 0, 64'h0);
    wait_b_done(40, kd, nv);
    check("br_done", 64'(kd), 16);
    check("br_nvalid", 64'(nv), 1);
    check("br_tries", 64'(b_tries), 1);
    check("br_queue_drained", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
